// File: rtl/y86_pkg.sv
// Shared Y86 definitions: status codes, PC controller state encoding and icode values
// used by the controller and the fetch/decode stages.
package y86_pkg;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_RUN  = 2'd1,
        CTRL_HALT = 2'd2
    } ctrl_state_e;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

endpackage

// File: rtl/y86_exc_prio.sv
// Exception prioritiser: imem ADR, then INS, then dmem ADR, then HLT.
// Purely combinational; no state, no backpressure.
module y86_exc_prio
    import y86_pkg::*;
(
    input  logic       imem_error,
    input  logic       instr_valid,
    input  logic       dmem_error,
    input  logic       hlt,
    output logic       exc,
    output logic [2:0] exc_stat
);

    always_comb begin
        exc      = 1'b0;
        exc_stat = STAT_AOK;
        if (imem_error) begin
            exc      = 1'b1;
            exc_stat = STAT_ADR;
        end else if (!instr_valid) begin
            exc      = 1'b1;
            exc_stat = STAT_INS;
        end else if (dmem_error) begin
            exc      = 1'b1;
            exc_stat = STAT_ADR;
        end else if (hlt) begin
            exc      = 1'b1;
            exc_stat = STAT_HLT;
        end
    end

endmodule

// File: rtl/y86_pc_ctrl.sv
// Architectural PC / status controller with run, single-step and restart; commit gates all writes.
// Optional performance counters enabled by defining Y86_PERF_CNT_EN.
module y86_pc_ctrl
    import y86_pkg::*;
#(
    parameter int                  PC_WIDTH  = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int                  CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic [PC_WIDTH-1:0]  updated_pc,
    input  logic                 hlt,
    input  logic                 imem_error,
    input  logic                 instr_valid,
    input  logic                 dmem_error,
    output logic [PC_WIDTH-1:0]  PC,
    output logic [2:0]           stat,
    output logic                 running,
    output logic                 commit,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt
);

    ctrl_state_e         state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [2:0]          stat_q;
    logic                running_q;
    logic                go;
    logic                exc;
    logic [2:0]          exc_stat;

    y86_exc_prio u_exc_prio (
        .imem_error  (imem_error),
        .instr_valid (instr_valid),
        .dmem_error  (dmem_error),
        .hlt         (hlt),
        .exc         (exc),
        .exc_stat    (exc_stat)
    );

    // Single-cycle core: the retiring instruction's writes land on this same edge.
    assign go     = !step_mode || step;
    assign commit = (state_q == CTRL_RUN) && go && !exc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CTRL_IDLE;
            pc_q      <= RESET_PC;
            stat_q    <= STAT_AOK;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                CTRL_IDLE: begin
                    if (start) begin
                        state_q   <= CTRL_RUN;
                        running_q <= 1'b1;
                    end
                end
                CTRL_RUN: begin
                    if (go) begin
                        if (exc) begin
                            state_q   <= CTRL_HALT;
                            stat_q    <= exc_stat;
                            running_q <= 1'b0;
                        end else begin
                            pc_q <= updated_pc;
                        end
                    end
                end
                CTRL_HALT: begin
                    if (start) begin
                        state_q <= CTRL_IDLE;
                        pc_q    <= RESET_PC;
                        stat_q  <= STAT_AOK;
                    end
                end
                default: begin
                    state_q   <= CTRL_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign PC      = pc_q;
    assign stat    = stat_q;
    assign running = running_q;

`ifdef Y86_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;
    logic                 restart;

    assign restart = (state_q == CTRL_HALT) && start;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (restart) begin
            cycle_cnt_d = '0;
            instr_cnt_d = '0;
        end else begin
            if (state_q == CTRL_RUN && cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
            if (commit && instr_cnt_q != '1)              instr_cnt_d = instr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule
